ped_crossing_ctrl: RTL
======================

# ped_crossing_ctrl

Pedestrian crossing controller sitting directly downstream of the traffic light controller. It consumes that block's `red`/`green`/`yellow` outputs and a raw pedestrian push-button, and grants a timed WALK then flashing-DON'T-WALK window aligned to the start of a vehicle red phase. It also flags illegal light patterns.

## Interface
- `WALK_TIME`, 3: cycles of steady WALK.
- `FLASH_TIME`, 2: cycles of flashing don't-walk after WALK.
- `DEBOUNCE`, 3: consecutive high synchronized samples needed to accept a press (≥1).
- `CNT_W`, 4: countdown width; `WALK_TIME+FLASH_TIME` ≤ 2^CNT_W−1.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `red`, `green`, `yellow` input 1 each: vehicle lights from traffic light controller; one-hot expected.
- `ped_btn` input 1: raw asynchronous button.
- `walk` output 1: steady WALK lamp.
- `dont_walk` output 1: DON'T WALK lamp.
- `flash` output 1: DON'T WALK is flashing.
- `countdown` output CNT_W: remaining crossing cycles; 0 when not crossing.
- `req_pending` output 1: accepted request awaiting service.
- `abort` output 1: one-cycle pulse when a crossing is cut short by red dropping.
- `fault` output 1: illegal light pattern present.

## Operation
- Button path: 2-flop synchronizer (`s1`, `s2`), then debounce counter (see Configuration). A new press is the rising edge of the accepted level. A held button gives exactly one request.
- `req_pending` is set on a new press and cleared on WALK entry. If the set and the clear fall on the same edge, the set wins. Presses during WALK/FLASH are latched for the next red phase. `req_pending` is preserved through FAULT.
- Red-start detect: `red_q` registers `red`; a red start is `red & ~red_q`. `red_q` resets to 1 so a red already high out of reset is not a start.
- States:
  - IDLE: `dont_walk`=1.
  - WALK: `walk`=1, `dont_walk`=0.
  - FLASH: `dont_walk`=1, `flash`=1.
  - FAULT: `dont_walk`=1, `flash`=1, `fault`=1.
- IDLE→WALK: on an edge where a red start is seen and `req_pending`=1. Load `countdown`=WALK_TIME+FLASH_TIME.
- WALK/FLASH: `countdown` decrements each edge. WALK→FLASH when `countdown`==FLASH_TIME+1. FLASH→IDLE when `countdown`==1; `countdown` becomes 0.
- Abort: `red`=0 sampled in WALK/FLASH while not completing → IDLE, `countdown`=0, `abort`=1 for one cycle.
- Fault: any edge where {red,green,yellow} is not one-hot → FAULT from any state. Exit to IDLE after two consecutive one-hot samples.
- Priority: fault > normal completion > abort > WALK entry.
- A request arriving mid-red waits for the next red start.

## Timing
- Reset values: `walk`=0, `dont_walk`=1, `flash`=0, `countdown`=0, `req_pending`=0, `abort`=0, `fault`=0. State is IDLE, synchronizer flops 0, debounce count 0, `red_q`=1.
- All outputs are registered; no combinational input→output paths.
- Press latency: let N be the first edge sampling `ped_btn`=1. `req_pending` is high after edge N+1+DEBOUNCE with the macro, or N+2 without it.
- Crossing: red start sampled at edge E gives WALK during E..E+WALK_TIME−1 and FLASH during the following FLASH_TIME edges. With the defaults, IDLE at E+5.
- `abort` and `fault` reflect the state entered at the same edge.
- Reset asserted mid-crossing: immediate return to reset values; the pending request is lost.

## Configuration
- `PED_DEBOUNCE_EN` defined:
  - The debounce counter increments while `s2`=1 and clears when `s2`=0.
  - The accepted level is 1 when the count reaches DEBOUNCE.
  - A glitch shorter than DEBOUNCE cycles is ignored.
- Not defined: the accepted level is `s2` directly and DEBOUNCE is unused. The counter logic is absent.

## Test plan
- Reset with `red`=1 held, no press → `dont_walk`=1, `walk`=0, `countdown`=0, no WALK entry on release.
- Press `ped_btn` high 5 cycles during green, then red rises (sampled at E) → `req_pending`=1 before E. `walk`=1 with `countdown` 5,4,3, then `flash`=1 with 2,1, then IDLE with `countdown`=0 and `req_pending`=0.
- With `PED_DEBOUNCE_EN`, a 2-cycle button pulse → `req_pending` stays 0. Without the macro, the same pulse sets `req_pending`.
- Red drops after 2 WALK cycles → next edge IDLE, `abort`=1 for exactly one cycle, `countdown`=0.
- Force `red`=`green`=1 for 1 cycle during WALK → FAULT with `fault`=1 and `flash`=1. It returns to IDLE after two one-hot samples with `req_pending` unchanged.
- Press during WALK → `req_pending`=1 after the crossing, served at the following red start.

Source files
------------

// File: rtl/ped_crossing_ctrl_if.sv
// Pedestrian crossing controller signal bundle.
// Vehicle lights and raw button in, crossing lamps and status out.
interface ped_crossing_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             red;
  logic             green;
  logic             yellow;
  logic             ped_btn;
  logic             walk;
  logic             dont_walk;
  logic             flash;
  logic [CNT_W-1:0] countdown;
  logic             req_pending;
  logic             abort;
  logic             fault;

  modport master (
    output red, green, yellow, ped_btn,
    input  walk, dont_walk, flash, countdown,
    input  req_pending, abort, fault
  );

  modport slave (
    input  red, green, yellow, ped_btn,
    output walk, dont_walk, flash, countdown,
    output req_pending, abort, fault
  );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: WALK/FLASH window at red start.
// Define PED_DEBOUNCE_EN to debounce the synchronized button.
module ped_crossing_ctrl #(
  parameter int WALK_TIME  = 3,
  parameter int FLASH_TIME = 2,
  parameter int DEBOUNCE   = 3,
  parameter int CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  ped_crossing_ctrl_if.slave  bus
);

  localparam int TOT = WALK_TIME + FLASH_TIME;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    FLASH,
    FAULT
  } state_e;

  if (DEBOUNCE < 1 || TOT > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("ped_crossing_ctrl: bad parameters");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic             red_q;
  logic             ok_q, ok_d;
  logic             req_q, req_d;
  logic             walk_q, walk_d;
  logic             dw_q, dw_d;
  logic             flash_q, flash_d;
  logic             abort_q, abort_d;
  logic             fault_q, fault_d;
  logic             press;
  logic             red_start;
  logic             one_hot;
  logic             enter;

`ifdef PED_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic [DB_W-1:0] db_q, db_d;

  // Count consecutive high samples; level rises as count hits DEBOUNCE.
  always_comb begin
    db_d  = '0;
    lvl_d = 1'b0;
    if (s2_q) begin
      lvl_d = (db_q >= DB_W'(DEBOUNCE - 1));
      if (db_q != DB_W'(DEBOUNCE)) begin
        db_d = db_q + 1'b1;
      end else begin
        db_d = db_q;
      end
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q <= '0;
    end else begin
      db_q <= db_d;
    end
  end
`else
  // Without debouncing the synchronized button is the level.
  always_comb begin
    lvl_d = s2_q;
  end
`endif

  assign press     = lvl_d & ~lvl_q;
  assign red_start = bus.red & ~red_q;
  assign one_hot   = (bus.red ^ bus.green ^ bus.yellow)
                   & ~(bus.red & bus.green & bus.yellow);

  // Next state, countdown and abort; fault wins over everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    abort_d = 1'b0;
    enter   = 1'b0;
    if (!one_hot) begin
      state_d = FAULT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (red_start && req_q) begin
            state_d = WALK;
            cnt_d   = CNT_W'(TOT);
            enter   = 1'b1;
          end
        end
        WALK, FLASH: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (!bus.red) begin
            state_d = IDLE;
            cnt_d   = '0;
            abort_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (state_q == WALK &&
                cnt_q == CNT_W'(FLASH_TIME + 1)) begin
              state_d = FLASH;
            end
          end
        end
        FAULT: begin
          if (ok_q) begin
            state_d = IDLE;
          end else begin
            ok_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Request latch (set beats clear) and lamps decoded from next state.
  always_comb begin
    req_d   = press | (req_q & ~enter);
    walk_d  = (state_d == WALK);
    dw_d    = (state_d != WALK);
    flash_d = (state_d == FLASH) || (state_d == FAULT);
    fault_d = (state_d == FAULT);
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      red_q   <= 1'b1;
      ok_q    <= 1'b0;
      req_q   <= 1'b0;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
      flash_q <= 1'b0;
      abort_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= bus.ped_btn;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      red_q   <= bus.red;
      ok_q    <= ok_d;
      req_q   <= req_d;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
      flash_q <= flash_d;
      abort_q <= abort_d;
      fault_q <= fault_d;
    end
  end

  assign bus.walk        = walk_q;
  assign bus.dont_walk   = dw_q;
  assign bus.flash       = flash_q;
  assign bus.countdown   = cnt_q;
  assign bus.req_pending = req_q;
  assign bus.abort       = abort_q;
  assign bus.fault       = fault_q;

endmodule
